// File: rtl/seq_mult_pkg.sv
// Shared types and helpers for the seq_mult_signed iterative multiplier.
package seq_mult_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Width needed to index 0..n-1, never less than one bit.
  function automatic int clog2_min1(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/seq_mult_iter_counter.sv
// Iteration index for seq_mult_signed: walks 0..B_WIDTH-1 and flags the last step.
module seq_mult_iter_counter
  import seq_mult_pkg::*;
#(
  parameter  int B_WIDTH = 8,
  localparam int CNT_W   = clog2_min1(B_WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             enable,
  input  logic             load,
  output logic [CNT_W-1:0] index,
  output logic             last_iter
);

  logic [CNT_W-1:0] idx_q, idx_d;

  // NOTE: combinational blocks assign a default first so no path can infer a latch.
  always_comb begin
    idx_d = idx_q;
    if (clear || load) idx_d = '0;
    else if (enable)   idx_d = idx_q + 1'b1;
  end

  // NOTE: reset is synchronous and active-low; it is just the highest-priority branch at the edge.
  always_ff @(posedge clk) begin
    if (!reset) idx_q <= '0;
    else        idx_q <= idx_d;
  end

  assign index     = idx_q;
  assign last_iter = (idx_q == CNT_W'(B_WIDTH - 1));

endmodule

// File: rtl/seq_mult_signed.sv
// Iterative shift-add multiplier, one multiplier bit per clock, signed or unsigned at runtime.
// Define SEQ_MULT_EARLY_TERM_EN to finish as soon as the remaining multiplier bits are all zero.
module seq_mult_signed
  import seq_mult_pkg::*;
#(
  parameter  int A_WIDTH = 8,
  parameter  int B_WIDTH = 8,
  localparam int P_WIDTH = A_WIDTH + B_WIDTH
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               signed_mode,
  input  logic               sync_clear,
  input  logic [A_WIDTH-1:0] data_in_a,
  input  logic [B_WIDTH-1:0] data_in_b,
  output logic               busy,
  output logic               ready,
  output logic [P_WIDTH-1:0] product
);

  localparam int CNT_W = clog2_min1(B_WIDTH);

  state_e             state_q;
  logic [P_WIDTH-1:0] acc_q, acc_d;
  logic [P_WIDTH-1:0] a_sh_q;
  logic [P_WIDTH-1:0] product_q;
  logic [B_WIDTH-1:0] b_q;
  logic               mode_q;
  logic               busy_q;
  logic               ready_q;

  logic [CNT_W-1:0]   iter_idx;
  logic               iter_last;
  logic               accept;
  logic               run_en;
  logic               bit_cur;
  logic               sub_now;
  logic               finish_run;

  // A start arriving while the ready pulse is still up is deliberately dropped.
  assign accept  = (state_q == IDLE) && start && !ready_q;
  assign run_en  = (state_q == RUN);
  assign bit_cur = b_q[iter_idx];
  assign sub_now = mode_q && iter_last;

  seq_mult_iter_counter #(
    .B_WIDTH (B_WIDTH)
  ) u_iter_counter (
    .clk       (clk),
    .reset     (reset),
    .clear     (sync_clear),
    .enable    (run_en),
    .load      (accept),
    .index     (iter_idx),
    .last_iter (iter_last)
  );

  // The multiplier's sign bit carries weight -2^(B_WIDTH-1), hence the subtract on the last step.
  always_comb begin
    acc_d = acc_q;
    if (bit_cur) acc_d = sub_now ? (acc_q - a_sh_q) : (acc_q + a_sh_q);
  end

`ifdef SEQ_MULT_EARLY_TERM_EN
  logic upper_zero;
  assign upper_zero = ((b_q >> iter_idx) == '0);
  assign finish_run = iter_last || upper_zero;
`else
  assign finish_run = iter_last;
`endif

  // NOTE: every register here is updated with non-blocking assignments so all state moves on the same edge.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= IDLE;
      acc_q     <= '0;
      a_sh_q    <= '0;
      product_q <= '0;
      b_q       <= '0;
      mode_q    <= 1'b0;
      busy_q    <= 1'b0;
      ready_q   <= 1'b0;
    end else if (sync_clear) begin
      state_q   <= IDLE;
      acc_q     <= '0;
      product_q <= '0;
      busy_q    <= 1'b0;
      ready_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          ready_q <= 1'b0;
          if (accept) begin
            a_sh_q  <= signed_mode ? {{B_WIDTH{data_in_a[A_WIDTH-1]}}, data_in_a}
                                   : {{B_WIDTH{1'b0}}, data_in_a};
            b_q     <= data_in_b;
            mode_q  <= signed_mode;
            acc_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= RUN;
          end
        end
        RUN: begin
          acc_q  <= acc_d;
          a_sh_q <= a_sh_q << 1;
          if (finish_run) begin
            busy_q  <= 1'b0;
            state_q <= DONE;
          end
        end
        DONE: begin
          product_q <= acc_q;
          ready_q   <= 1'b1;
          state_q   <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy    = busy_q;
  assign ready   = ready_q;
  assign product = product_q;

endmodule
